// File: rtl/gpio_led_fader.sv
`default_nettype none
// ============================================================================
// Module      : gpio_led_fader
// Description : Fades an LED on or off in response to a GPIO level. i_gpio is
//               synchronised into the wb_clk domain, and an OFF/UP/ON/DOWN
//               state machine then ramps a brightness level one step every
//               RAMP_DIV cycles. A free-running counter turns that level into
//               a registered PWM drive on o_led.
//
// Ports       : wb_clk   - system clock
//               wb_rst   - asynchronous active-high reset
//               i_gpio   - asynchronous GPIO level, 1 = LED requested on
//               o_led    - registered PWM LED drive (active low if ACTIVE_LOW=1)
//               o_level  - current brightness level, 0..2^PWM_BITS-1
//               o_busy   - high while the level is ramping (UP or DOWN)
//
// Options     : `define LED_GAMMA_EN for a squared (perceptual) duty curve.
//               Without it the duty cycle is linear in the level.
//
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_led_fader #(
    parameter int PWM_BITS    = 8,
    parameter int RAMP_DIV    = 1024,
    parameter int SYNC_STAGES = 2,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                wb_clk,
    input  logic                wb_rst,
    input  logic                i_gpio,
    output logic                o_led,
    output logic [PWM_BITS-1:0] o_level,
    output logic                o_busy
);

    localparam int                  c_PRE_W    = $clog2(RAMP_DIV);
    localparam logic [PWM_BITS-1:0] c_MAX      = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] c_MAX_M1   = {{(PWM_BITS-1){1'b1}}, 1'b0};
    localparam logic [PWM_BITS-1:0] c_ONE      = {{(PWM_BITS-1){1'b0}}, 1'b1};
    localparam logic [c_PRE_W-1:0]  c_PRE_ONE  = {{(c_PRE_W-1){1'b0}}, 1'b1};
    localparam logic [c_PRE_W-1:0]  c_TICK_AT  = c_PRE_W'(RAMP_DIV - 1);
    localparam logic                c_DARK     = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_UP   = 2'd1,
        S_ON   = 2'd2,
        S_DOWN = 2'd3
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [PWM_BITS-1:0]    r_level;
    logic [c_PRE_W-1:0]     r_presc;
    logic [PWM_BITS-1:0]    r_pwm_cnt;
    logic                   r_busy;
    logic                   r_led;

    logic                   w_gpio_s;
    logic                   w_tick;
    logic [PWM_BITS-1:0]    w_duty;
    logic                   w_lit;

    // ------------------------------------------------------------------------
    // Input synchroniser: i_gpio enters at bit 0, is used from the top bit.
    // ------------------------------------------------------------------------
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_gpio};
        end
    end

    assign w_gpio_s = r_sync[SYNC_STAGES-1];

    // The prescaler only runs in the ramp states, so the tick is qualified there.
    assign w_tick = ((r_state == S_UP) || (r_state == S_DOWN)) && (r_presc == c_TICK_AT);

    // ------------------------------------------------------------------------
    // Ramp state machine. The level saturates: a reversal can leave DOWN
    // sitting at 0 (or UP at MAX), and the next tick then just finishes the
    // ramp at that end instead of stepping past it.
    // ------------------------------------------------------------------------
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            r_state <= S_OFF;
            r_level <= '0;
            r_presc <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_OFF: begin
                    if (w_gpio_s) begin
                        r_state <= S_UP;
                        r_busy  <= 1'b1;
                        r_presc <= '0;
                    end
                end
                S_UP: begin
                    if (!w_gpio_s) begin
                        r_state <= S_DOWN;
                        r_presc <= '0;
                    end else if (w_tick) begin
                        r_presc <= '0;
                        if (r_level >= c_MAX_M1) begin
                            r_level <= c_MAX;
                            r_state <= S_ON;
                            r_busy  <= 1'b0;
                        end else begin
                            r_level <= r_level + c_ONE;
                        end
                    end else begin
                        r_presc <= r_presc + c_PRE_ONE;
                    end
                end
                S_ON: begin
                    if (!w_gpio_s) begin
                        r_state <= S_DOWN;
                        r_busy  <= 1'b1;
                        r_presc <= '0;
                    end
                end
                S_DOWN: begin
                    if (w_gpio_s) begin
                        r_state <= S_UP;
                        r_presc <= '0;
                    end else if (w_tick) begin
                        r_presc <= '0;
                        if (r_level <= c_ONE) begin
                            r_level <= '0;
                            r_state <= S_OFF;
                            r_busy  <= 1'b0;
                        end else begin
                            r_level <= r_level - c_ONE;
                        end
                    end else begin
                        r_presc <= r_presc + c_PRE_ONE;
                    end
                end
                default: begin
                    r_state <= S_OFF;
                    r_level <= '0;
                    r_presc <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Duty selection
    // ------------------------------------------------------------------------
`ifdef LED_GAMMA_EN
    logic [2*PWM_BITS-1:0] w_sq;
    assign w_sq   = {{PWM_BITS{1'b0}}, r_level} * {{PWM_BITS{1'b0}}, r_level};
    assign w_duty = w_sq[2*PWM_BITS-1:PWM_BITS];
`else
    assign w_duty = r_level;
`endif

    // Full level is forced fully lit; a plain compare would top out one
    // count short of 100 %.
    assign w_lit = (r_level == c_MAX) ? 1'b1 : (r_pwm_cnt < w_duty);

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            r_pwm_cnt <= '0;
            r_led     <= c_DARK;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + c_ONE;
            r_led     <= w_lit ^ c_DARK;
        end
    end

    assign o_led   = r_led;
    assign o_level = r_level;
    assign o_busy  = r_busy;

endmodule
`default_nettype wire
